// File: rtl/m_unit_arbiter.sv
// Two-requester round-robin front end for a single RV32M multiply/divide unit.
// One op in flight; m_valid the cycle after a grant; result held until the owner's resp_ready.
module m_unit_arbiter #(
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [63:0]        req_instruction,
  input  logic [63:0]        req_rs1,
  input  logic [63:0]        req_rs2,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [31:0]        resp_rd,
  output logic [TAG_W-1:0]   resp_tag,
  output logic               resp_error,
  output logic               m_valid,
  output logic [31:0]        m_instruction,
  output logic [31:0]        m_rs1,
  output logic [31:0]        m_rs2,
  input  logic               m_ready,
  input  logic [31:0]        m_rd,
  input  logic               m_busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             own_q, own_d;
  logic [31:0]      insn_q, insn_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [31:0]      rd_q, rd_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;

  logic             gnt;
  logic             accept;
  logic             legal;
  logic [31:0]      sel_insn;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt      = (&req_valid) ? ~last_q : ~req_valid[0];
    accept   = (state_q == IDLE) && !m_busy && (|req_valid);
    sel_insn = gnt ? req_instruction[63:32] : req_instruction[31:0];
    legal    = (sel_insn[6:0] == 7'b0110011) && (sel_insn[31:25] == 7'b0000001);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = legal ? ISSUE : RESP;
      ISSUE:   state_d = WAIT;
      WAIT:    if (m_ready) state_d = RESP;
      RESP:    if (resp_ready[own_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    own_d  = own_q;
    insn_d = insn_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rd_d   = rd_q;
    tag_d  = tag_q;
    err_d  = err_q;
    if (accept) begin
      own_d  = gnt;
      insn_d = sel_insn;
      rs1_d  = gnt ? req_rs1[63:32] : req_rs1[31:0];
      rs2_d  = gnt ? req_rs2[63:32] : req_rs2[31:0];
      tag_d  = gnt ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
      // Illegal ops skip the M unit and answer straight from here.
      if (!legal) begin
        rd_d  = '0;
        err_d = 1'b1;
      end
    end
    if ((state_q == WAIT) && m_ready) begin
      rd_d  = m_rd;
      err_d = 1'b0;
    end
    if ((state_q == RESP) && resp_ready[own_q]) begin
      last_d = own_q;
    end
  end

  always_comb begin
    req_ready     = accept ? (2'b01 << gnt) : 2'b00;
    resp_valid    = (state_q == RESP) ? (2'b01 << own_q) : 2'b00;
    m_valid       = (state_q == ISSUE);
    m_instruction = insn_q;
    m_rs1         = rs1_q;
    m_rs2         = rs2_q;
    resp_rd       = rd_q;
    resp_tag      = tag_q;
    resp_error    = err_q;
  end
endmodule

// File: tb/tb_m_unit_arbiter.sv
// Randomized scoreboard bench for m_unit_arbiter with a behavioural RV32M unit and protocol model.
module tb_m_unit_arbiter;
  localparam int TAG_W = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [63:0]        req_instruction;
  logic [63:0]        req_rs1;
  logic [63:0]        req_rs2;
  logic [2*TAG_W-1:0] req_tag;
  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [31:0]        resp_rd;
  logic [TAG_W-1:0]   resp_tag;
  logic               resp_error;
  logic               m_valid;
  logic [31:0]        m_instruction;
  logic [31:0]        m_rs1;
  logic [31:0]        m_rs2;
  logic               m_ready;
  logic [31:0]        m_rd;
  logic               m_busy;

  logic v0 = 1'b0, v1 = 1'b0;
  logic [31:0] ins0 = '0, ins1 = '0, a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [TAG_W-1:0] t0 = '0, t1 = '0;
  assign req_valid       = {v1, v0};
  assign req_instruction = {ins1, ins0};
  assign req_rs1         = {a1, a0};
  assign req_rs2         = {b1, b0};
  assign req_tag         = {t1, t0};

  logic busy_force = 1'b0;
  logic m_pend = 1'b0;
  assign m_busy = busy_force | m_pend;

  bit       rr_force = 1'b0;
  logic [1:0] rr_val = 2'b11;
  int       m_k_force = 0;

  always #5 clk = ~clk;

  m_unit_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_instruction(req_instruction), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd(resp_rd), .resp_tag(resp_tag), .resp_error(resp_error),
    .m_valid(m_valid), .m_instruction(m_instruction), .m_rs1(m_rs1), .m_rs2(m_rs2),
    .m_ready(m_ready), .m_rd(m_rd), .m_busy(m_busy)
  );

  typedef struct {
    logic [31:0]      rd;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   checks = 0;
  int   fails  = 0;
  int   mv_cnt = 0;
  int   gnt_log[$];
  bit   log_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    fails++;
    $display("FAIL %s: timed out or missing (t=%0t)", nm, $time);
  endtask

  function automatic bit is_legal(input logic [31:0] insn);
    return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001);
  endfunction

  // RV32M semantics straight from the ISA definition.
  function automatic logic [31:0] rv32m(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, su, p;
    logic [63:0] u;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    su = longint'({32'b0, b});
    ia = int'(a);
    ib = int'(b);
    case (insn[14:12])
      3'd0: return a * b;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * su; return p[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            else return ia / ib;
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            else return ia % ib;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request on requester i, queues its expected response, waits for the transfer.
  task automatic issue(input int i, input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input bit use_exp, input logic [31:0] erd);
    exp_t e;
    int n;
    e.tag = tag;
    if (is_legal(insn)) begin
      e.err = 1'b0;
      e.rd  = use_exp ? erd : rv32m(insn, a, b);
    end else begin
      e.err = 1'b1;
      e.rd  = '0;
    end
    if (i == 0) begin
      exp_q0.push_back(e);
      ins0 = insn; a0 = a; b0 = b; t0 = tag; v0 = 1'b1;
    end else begin
      exp_q1.push_back(e);
      ins1 = insn; a1 = a; b1 = b; t1 = tag; v1 = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_valid[i] && req_ready[i]) && n < 500);
    if (n >= 500) flag($sformatf("accept_req%0d", i));
    tick();
    if (i == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) flag(nm);
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] x;
    x = $urandom;
    x[6:0]   = 7'b0110011;
    x[31:25] = 7'b0000001;
    case ($urandom_range(0, 9))
      0: x[31:25] = 7'($urandom);
      1: x[6:0]   = 7'($urandom);
      default: ;
    endcase
    return x;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Behavioural M unit: k>=1 cycles after m_valid returns a one-cycle m_ready; stray strobes when idle.
  initial begin
    int cnt;
    logic [31:0] res;
    m_ready = 1'b0;
    m_rd    = '0;
    cnt     = 0;
    res     = '0;
    forever begin
      tick();
      m_ready = 1'b0;
      if (m_pend) begin
        cnt--;
        if (cnt == 0) begin
          m_ready = 1'b1;
          m_rd    = res;
          m_pend  = 1'b0;
        end
      end else if (m_valid === 1'b1) begin
        m_pend = 1'b1;
        cnt    = (m_k_force > 0) ? m_k_force : $urandom_range(1, 4);
        res    = rv32m(m_instruction, m_rs1, m_rs2);
      end else if ($urandom_range(0, 7) == 0) begin
        m_ready = 1'b1;
        m_rd    = $urandom;
      end
    end
  end

  initial begin
    resp_ready = 2'b00;
    forever begin
      tick();
      resp_ready = rr_force ? rr_val : 2'($urandom_range(0, 3));
    end
  end

  // Protocol-level model of the arbiter: 0 free, 1 start pulse due, 2 awaiting result, 3 answering.
  int phase  = 0;
  int own    = 0;
  int last_g = 1;
  bit rst_chk = 1'b0;

  always @(negedge clk) begin : mon
    logic [1:0]  er;
    logic [31:0] insn;
    int          g;
    exp_t        e;
    if (reset) begin
      if (phase != 0) begin
        if (own == 0 && exp_q0.size() != 0) void'(exp_q0.pop_front());
        if (own == 1 && exp_q1.size() != 0) void'(exp_q1.pop_front());
      end
      phase   = 0;
      last_g  = 1;
      rst_chk = 1'b1;
    end else begin
      if (rst_chk) begin
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rd", resp_rd, 32'h0);
        chk("rst_resp_tag", 32'(resp_tag), 32'h0);
        chk("rst_resp_error", 32'(resp_error), 32'h0);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_instruction", m_instruction, 32'h0);
        chk("rst_m_rs1", m_rs1, 32'h0);
        chk("rst_m_rs2", m_rs2, 32'h0);
        rst_chk = 1'b0;
      end
      if (m_valid === 1'b1) mv_cnt++;
      chk("resp_valid", 32'(resp_valid), (phase == 3) ? (32'h1 << own) : 32'h0);
      chk("m_valid", 32'(m_valid), 32'(phase == 1));
      if (phase == 3) begin
        if ((own == 0 && exp_q0.size() == 0) || (own == 1 && exp_q1.size() == 0)) begin
          flag("resp_unexpected");
        end else begin
          e = (own == 0) ? exp_q0[0] : exp_q1[0];
          chk($sformatf("resp_rd_req%0d", own), resp_rd, e.rd);
          chk($sformatf("resp_tag_req%0d", own), 32'(resp_tag), 32'(e.tag));
          chk($sformatf("resp_error_req%0d", own), 32'(resp_error), 32'(e.err));
        end
      end
      er = 2'b00;
      g  = 0;
      if (phase == 0 && !m_busy && req_valid != 2'b00) begin
        g  = (req_valid == 2'b11) ? (1 - last_g) : (req_valid[0] ? 0 : 1);
        er = (g == 0) ? 2'b01 : 2'b10;
      end
      chk("req_ready", 32'(req_ready), 32'(er));
      case (phase)
        0: if (er != 2'b00) begin
             own  = g;
             insn = (g == 0) ? req_instruction[31:0] : req_instruction[63:32];
             phase = is_legal(insn) ? 1 : 3;
             if (log_en) gnt_log.push_back(g);
           end
        1: phase = 2;
        2: if (m_ready) phase = 3;
        default: if (resp_ready[own]) begin
             if (own == 0 && exp_q0.size() != 0) void'(exp_q0.pop_front());
             if (own == 1 && exp_q1.size() != 0) void'(exp_q1.pop_front());
             last_g = own;
             phase  = 0;
           end
      endcase
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Both requesters valid from reset: grants must alternate starting with requester 0.
    rr_force = 1'b1;
    rr_val   = 2'b11;
    log_en   = 1'b1;
    fork
      begin
        issue(0, 32'h0200_3033, 32'h1111_FFFF, 32'h1111_FFFF, 5'd1, 1'b1, 32'h0123_6543);
        issue(0, 32'h0200_3033, 32'h1111_FFFF, 32'h1111_FFFF, 5'd2, 1'b1, 32'h0123_6543);
      end
      begin
        issue(1, 32'h0200_5033, 32'h0000_000D, 32'h0000_0005, 5'd3, 1'b1, 32'h0000_0002);
        issue(1, 32'h0200_5033, 32'h0000_000D, 32'h0000_0005, 5'd4, 1'b1, 32'h0000_0002);
      end
    join
    drain("fair_drain");
    log_en = 1'b0;
    chk("fair_count", 32'(gnt_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("fair_order", (gnt_log.size() > k) ? 32'(gnt_log[k]) : 32'hDEAD, 32'(k % 2));

    // MUL on requester 0, exactly one start pulse.
    c0 = mv_cnt;
    issue(0, 32'h0200_0033, 32'h1111_FFFF, 32'h1111_FFFF, 5'd7, 1'b1, 32'hDDDC_0001);
    drain("mul_drain");
    chk("mul_m_valid_pulses", 32'(mv_cnt - c0), 32'd1);

    // ADD is not an M op: error response, M unit untouched.
    c0 = mv_cnt;
    issue(1, 32'h0000_0033, 32'h1234_5678, 32'h0000_0001, 5'd9, 1'b0, 32'h0);
    drain("illegal_drain");
    chk("illegal_m_valid_pulses", 32'(mv_cnt - c0), 32'd0);

    // DIV by zero held under backpressure while requester 1 waits.
    rr_val = 2'b00;
    fork
      issue(0, 32'h0200_4033, 32'hFFFF_FFF3, 32'h0000_0000, 5'd11, 1'b1, 32'hFFFF_FFFF);
      begin
        tick();
        tick();
        issue(1, 32'h0200_0033, 32'h0000_0003, 32'h0000_0004, 5'd12, 1'b1, 32'h0000_000C);
      end
      begin
        n = 0;
        while (resp_valid[0] !== 1'b1 && n < 200) begin
          @(negedge clk);
          n++;
        end
        if (n >= 200) flag("bp_resp_valid");
        tick();
        repeat (5) tick();
        rr_val = 2'b11;
      end
    join
    drain("bp_drain");

    // m_busy holds off the grant.
    busy_force = 1'b1;
    fork
      issue(0, 32'h0200_0033, 32'h0000_0006, 32'h0000_0007, 5'd13, 1'b1, 32'h0000_002A);
      begin
        repeat (6) tick();
        busy_force = 1'b0;
      end
    join
    drain("busy_drain");

    // Reset while the DIV is waiting on the M unit; its late m_ready must be ignored.
    m_k_force = 6;
    issue(0, 32'h0200_4033, 32'h0000_0064, 32'h0000_0007, 5'd14, 1'b0, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_k_force = 0;
    repeat (8) tick();
    issue(0, 32'h0200_6033, 32'hFFFF_FFF3, 32'h0000_0005, 5'd15, 1'b1, 32'hFFFF_FFFD);
    drain("rem_drain");

    // Random traffic from both requesters with random backpressure.
    rr_force = 1'b0;
    fork
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(0, 3)) tick();
        issue(0, rand_insn(), rand_op(), rand_op(), 5'($urandom), 1'b0, 32'h0);
      end
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(0, 3)) tick();
        issue(1, rand_insn(), rand_op(), rand_op(), 5'($urandom), 1'b0, 32'h0);
      end
    join
    drain("random_drain");
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end
endmodule

// File: doc/m_unit_arbiter.md
# m_unit_arbiter

Shares a single `riscv_m_unit` multiply/divide datapath between two requesters, for example two issue ports or an integer pipe plus a coprocessor port.
- Accepts one request at a time using round-robin arbitration.
- Checks that the instruction is a legal RV32M opcode.
- Sequences the M unit's valid/ready protocol.
- Holds each result in an output register until the owning requester accepts it.
- Sits between the requesters and the M unit; only one operation is outstanding at a time.

## Interface
Parameters:
- TAG_W, 5, width of the per-request tag (destination register index), echoed back with the result.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  one bit per requester; request is pending.
- req_ready  out  2  one-hot; transfer occurs when req_valid[i] and req_ready[i] are both high.
- req_instruction  in  64  requester i in bits [32i+31:32i].
- req_rs1  in  64  operand A per requester, same packing.
- req_rs2  in  64  operand B per requester, same packing.
- req_tag  in  2*TAG_W  tag per requester, same packing.
- resp_valid  out  2  one-hot; result available for requester i.
- resp_ready  in  2  requester i accepts the result.
- resp_rd  out  32  result value.
- resp_tag  out  TAG_W  tag of the completed request.
- resp_error  out  1  request was not a legal M-extension instruction.
- m_valid  out  1  one-cycle start pulse to the M unit.
- m_instruction  out  32  instruction to the M unit.
- m_rs1  out  32  operand A to the M unit.
- m_rs2  out  32  operand B to the M unit.
- m_ready  in  1  M unit result strobe.
- m_rd  in  32  M unit result.
- m_busy  in  1  M unit is occupied.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grants only when m_busy=0 and at least one req_valid is high.
  - Round-robin: if both requesters are valid, grant the one that was not granted last. Otherwise grant the single valid one.
  - req_ready[g] is combinational and high only in this cycle.
  - Latches instruction, rs1, rs2, tag and g.
- Legality check on the latched instruction: opcode[6:0]=7'b0110011 and funct7[31:25]=7'b0000001.
  - Legal: go to ISSUE.
  - Illegal: go to RESP with resp_error=1 and resp_rd=0. The M unit is never started.
- ISSUE: m_valid=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Sample m_ready each cycle.
  - On m_ready=1, capture m_rd into resp_rd, set resp_error=0, go to RESP.
  - m_ready outside WAIT is ignored.
- RESP:
  - resp_valid[g]=1 with resp_rd and resp_tag held stable.
  - On resp_ready[g]=1, go to IDLE and record g as the last grant.
  - resp_ready on the non-owning bit is ignored.
- m_instruction, m_rs1 and m_rs2 hold the latched values from acceptance until the next acceptance; they are stable around the m_valid pulse.
- Results are passed through unmodified. All div-by-zero and overflow semantics belong to the M unit.
- No new request is accepted until the current response is consumed.

## Timing
- Reset (clk edge with reset=1):
  - State IDLE; last-grant pointer = 1, so requester 0 wins the first tie.
  - All outputs 0: req_ready, resp_valid, resp_rd, resp_tag, resp_error, m_valid, m_instruction, m_rs1, m_rs2.
- Reset mid-operation (ISSUE, WAIT or RESP):
  - The operation is dropped with no response.
  - Outputs are 0 after that edge.
  - An m_ready arriving after reset is ignored (the FSM is in IDLE).
- Legal request accepted at cycle T:
  - m_valid at T+1.
  - If m_ready arrives at T+1+k (k≥1), resp_valid rises at T+2+k.
- Illegal request accepted at T: resp_valid at T+1.
- Back-to-back: earliest next acceptance is the cycle after the resp_valid/resp_ready handshake.
- Response path to the requesters has no combinational path from m_ready.

## Test plan
- MUL, legal request on requester 0:
  - Stimulus: req0 insn 02000033, rs1=1111FFFF, rs2=1111FFFF, tag=7.
  - Response: exactly one m_valid pulse; resp_valid[0] with resp_rd=DDDC0001, resp_tag=7, resp_error=0.
- Arbitration fairness:
  - Stimulus: both requesters valid continuously from reset, req0 MULHU 1111FFFF*1111FFFF, req1 DIVU 0000000D/00000005.
  - Response: grants alternate 0,1,0,1; results 01236543 and 00000002.
- Illegal instruction:
  - Stimulus: req1 insn 00000033 (ADD).
  - Response: m_valid never asserted; resp_valid[1] at T+1 with resp_error=1, resp_rd=0.
- Response backpressure:
  - Stimulus: DIV FFFFFFF3/00000000 with resp_ready low for 5 cycles, req1 valid throughout.
  - Response: resp_valid[0] held with resp_rd=FFFFFFFF stable; req_ready stays 0 until the handshake.
- Busy gating:
  - Stimulus: m_busy=1 in IDLE with req0 valid.
  - Response: no grant; grant in the first cycle m_busy=0.
- Reset during WAIT:
  - Stimulus: assert reset for one cycle mid-DIV.
  - Response: all outputs 0 and no response. A subsequent REM FFFFFFF3/00000005 returns FFFFFFFD normally.
